// File: rtl/fetch_stage_pkg.sv
// Shared constants, entry payload type and helpers for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned FQ_DEPTH_DFLT = 2;
    localparam int unsigned CNT_W         = 2;

    localparam logic [XLEN-1:0] PC_RESET_DFLT = 32'h1c00_0000;

    // Reset assertion level and boolean constants used across the fetch slice
    localparam logic REST_EN = 1'b1;
    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;

    // One queued instruction: fetch address plus the returned word
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    // Force an address onto a word boundary
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of fetched instructions with push/pop/flush.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  fq_entry_t            push_data,
    input  logic                 pop,
    input  logic                 flush,
    output fq_entry_t            head,
    output logic [CNT_W-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                full_c;

    // Advance a pointer with wrap at the queue depth
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c = (count == CNT_W'(DEPTH));
    assign head   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (reset == REST_EN || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && !flush && full_c));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues word requests to inst RAM, queues returned
// words with their addresses and hands them to decode with valid/ready.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DFLT,
    parameter int unsigned FQ_DEPTH = FQ_DEPTH_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    output logic        right_valid,
    input  logic        right_ready
);

    logic [31:0]      fetch_pc;
    logic             pending;
    logic [31:0]      pending_pc;
    logic [CNT_W-1:0] fq_count;
    fq_entry_t        fq_head;
    fq_entry_t        push_data_c;
    logic             fire_c;
    logic             push_c;
    logic             issue_c;
    logic [2:0]       occ_after_c;

    // Handshake and issue decision; the queue must have room for everything in flight
    always_comb begin
        right_valid = (reset != REST_EN) && (fq_count != '0);
        fire_c      = right_valid && right_ready;
        occ_after_c = 3'(fq_count) + 3'(pending) - 3'(fire_c);
        issue_c     = (reset != REST_EN) && !br_taken && (occ_after_c < 3'(FQ_DEPTH));
        push_c      = pending && !br_taken && (reset != REST_EN);
        push_data_c = '{pc: pending_pc, inst: inst_sram_rdata};
    end

    assign inst_sram_en   = issue_c;
    assign inst_sram_addr = fetch_pc;
    assign PC             = right_valid ? fq_head.pc   : '0;
    assign Inst           = right_valid ? fq_head.inst : '0;

    // Fetch address and outstanding-request tracking; redirect drops the in-flight word
    always_ff @(posedge clk) begin
        if (reset == REST_EN) begin
            fetch_pc   <= align_word(PC_RESET);
            pending    <= FALSE;
            pending_pc <= '0;
        end else if (br_taken) begin
            fetch_pc <= align_word(br_target);
            pending  <= FALSE;
        end else begin
            pending <= issue_c;
            if (issue_c) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (fire_c),
        .flush     (br_taken),
        .head      (fq_head),
        .count     (fq_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus randomized run against a queue model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] PC;
    logic [31:0] Inst;
    logic        right_valid;
    logic        right_ready;

    always #5 clk = ~clk;

    fetch_stage #(
        .PC_RESET (32'h1c00_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .PC              (PC),
        .Inst            (Inst),
        .right_valid     (right_valid),
        .right_ready     (right_ready)
    );

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        addr_mode;
    logic        last_req_v;
    logic [31:0] last_req_addr;
    logic        s_en, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;
    vec_t        tbl[$];

    // Instruction memory contents as a function of address
    function automatic logic [31:0] ram_f(input logic [31:0] a);
        return addr_mode ? a : ({a[15:0], a[31:16]} ^ 32'h5a5a_c3c3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic br, input logic [31:0] tgt, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic een, input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.exp_v = ev; v.exp_pc = epc; v.exp_en = een; v.exp_addr = eaddr;
        tbl.push_back(v);
    endtask

    // Apply inputs just after the falling edge, answer last cycle's request, then sample
    task automatic drive(input logic rst, input logic br, input logic [31:0] tgt, input logic rdy);
        reset       = rst;
        br_taken    = br;
        br_target   = tgt;
        right_ready = rdy;
        inst_sram_rdata = last_req_v ? ram_f(last_req_addr) : $urandom();
        #1;
        s_en    = inst_sram_en;
        s_addr  = inst_sram_addr;
        s_valid = right_valid;
        s_pc    = PC;
        s_inst  = Inst;
    endtask

    task automatic advance();
        @(posedge clk);
        last_req_v    = s_en;
        last_req_addr = s_addr;
        @(negedge clk);
    endtask

    initial begin
        ent_t        mq[$];
        ent_t        e;
        logic        m_infl;
        logic [31:0] m_infl_pc;
        logic [31:0] m_next;
        logic        rst, br, rdy, ev, fire, een;
        logic [31:0] tgt, epc, einst;
        int          occ;

        reset = 1'b1; br_taken = 1'b0; br_target = '0; right_ready = 1'b0;
        inst_sram_rdata = '0;
        last_req_v = 1'b0; last_req_addr = '0;
        addr_mode = 1'b1;
        m_infl = 1'b0; m_infl_pc = '0; m_next = '0;

        // reset, startup latency, stall with full queue, release
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0000);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0004);
        add(0, 0, 0, 0, 1, 32'h1c00_0000, 0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h1c00_0000, 0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h1c00_0000, 0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h1c00_0000, 0, 32'h0);
        add(0, 0, 0, 0, 1, 32'h1c00_0000, 0, 32'h0);
        add(0, 0, 0, 1, 1, 32'h1c00_0000, 1, 32'h1c00_0008);
        add(0, 0, 0, 1, 1, 32'h1c00_0004, 1, 32'h1c00_000c);
        add(0, 0, 0, 1, 1, 32'h1c00_0008, 1, 32'h1c00_0010);
        add(0, 0, 0, 1, 1, 32'h1c00_000c, 1, 32'h1c00_0014);
        // redirect with a queued entry and a response in flight
        add(0, 1, 32'h1c00_0103, 0, 1, 32'h1c00_0010, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0100);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0104);
        add(0, 0, 0, 1, 1, 32'h1c00_0100, 1, 32'h1c00_0108);
        // redirect coincident with a transfer
        add(0, 1, 32'h1c00_0200, 1, 1, 32'h1c00_0104, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0200);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0204);
        add(0, 0, 0, 1, 1, 32'h1c00_0200, 1, 32'h1c00_0208);
        // back-to-back redirects, the later one to the top of the address space
        add(0, 1, 32'h0000_0040, 1, 1, 32'h1c00_0204, 0, 32'h0);
        add(0, 1, 32'hffff_fffc, 1, 0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'hffff_fffc);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h0000_0000);
        add(0, 0, 0, 1, 1, 32'hffff_fffc, 1, 32'h0000_0004);
        add(0, 0, 0, 1, 1, 32'h0000_0000, 1, 32'h0000_0008);
        // one-cycle reset with a queued entry and a response in flight
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0000);
        add(0, 0, 0, 1, 0, 32'h0,         1, 32'h1c00_0004);
        add(0, 0, 0, 1, 1, 32'h1c00_0000, 1, 32'h1c00_0008);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
            chk($sformatf("vec%0d right_valid", i), 32'(s_valid), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d PC", i), s_pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d Inst", i), s_inst, tbl[i].exp_pc);
            chk($sformatf("vec%0d inst_sram_en", i), 32'(s_en), 32'(tbl[i].exp_en));
            if (tbl[i].exp_en) begin
                chk($sformatf("vec%0d inst_sram_addr", i), s_addr, tbl[i].exp_addr);
            end
            advance();
        end

        // randomized traffic against a queue-level model
        addr_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(99) == 0);
            br  = ($urandom_range(11) == 0);
            tgt = ($urandom_range(3) == 0) ? (32'hffff_fff0 + 32'($urandom_range(15))) : $urandom();
            rdy = ($urandom_range(9) < 7);

            ev    = !rst && (mq.size() != 0);
            epc   = ev ? mq[0].pc   : 32'h0;
            einst = ev ? mq[0].inst : 32'h0;
            fire  = ev && rdy;
            occ   = mq.size() + int'(m_infl) - int'(fire);
            een   = !rst && !br && (occ < 2);

            drive(rst, br, tgt, rdy);
            chk($sformatf("rnd%0d right_valid", c), 32'(s_valid), 32'(ev));
            chk($sformatf("rnd%0d PC", c), s_pc, epc);
            chk($sformatf("rnd%0d Inst", c), s_inst, einst);
            chk($sformatf("rnd%0d inst_sram_en", c), 32'(s_en), 32'(een));
            if (een) begin
                chk($sformatf("rnd%0d inst_sram_addr", c), s_addr, m_next);
            end

            if (rst) begin
                mq.delete();
                m_infl = 1'b0;
                m_next = 32'h1c00_0000;
            end else if (br) begin
                mq.delete();
                m_infl = 1'b0;
                m_next = {tgt[31:2], 2'b00};
            end else begin
                if (fire) begin
                    void'(mq.pop_front());
                end
                if (m_infl) begin
                    e.pc   = m_infl_pc;
                    e.inst = ram_f(m_infl_pc);
                    mq.push_back(e);
                end
                m_infl    = een;
                m_infl_pc = m_next;
                if (een) begin
                    m_next = m_next + 32'd4;
                end
            end
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
